instr_fetch_unit: RTL and testbench

- Instruction fetch stage of the RV32I core; sits directly upstream of the combinational instruction ROM.
- Drives the ROM byte address from an internal fetch PC and captures the returned word into a small prefetch FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump) from execute, which flushes the FIFO and restarts fetch at the new PC.

---
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   RV32I instruction fetch stage. Drives a combinational instruction ROM
//   from the fetch PC, captures {pc, instr} into a small prefetch FIFO and
//   presents the FIFO head to decode with a valid/ready handshake. A redirect
//   from execute flushes the FIFO and restarts fetch at the new PC.
//
// Optional build macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned PC sets a sticky fetch_err,
//               flushes the FIFO and parks the FSM in HALT until reset.
//   undefined : fetch_err is 0, redirect_pc[1:0] is ignored (forced to 0).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   imem_addr      out  ROM byte address (= fetch PC)
//   imem_data      in   ROM word at imem_addr[31:2], same cycle
//   id_valid       out  FIFO head valid for decode
//   id_ready       in   decode accepts head this cycle
//   id_instr       out  head instruction, NOP_INSTR when empty
//   id_pc          out  head PC, 0 when empty
//   redirect_valid in   execute requests a PC change
//   redirect_pc    in   new fetch PC
//   fetch_err      out  sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic          fetch_err_q;

  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          misalign_s;
  logic [31:0]   redirect_tgt_s;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_s     = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt_s = redirect_pc;
`else
  assign misalign_s     = 1'b0;
  // Low address bits are meaningless without the checker, so drop them.
  assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign empty_s   = (count_q == {CW{1'b0}});
  assign full_s    = (count_q == CW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  // A redirect hides the (about to be flushed) head from decode.
  assign id_valid  = ~empty_s & ~redirect_valid;
  assign pop_s     = id_valid & id_ready;
  // A same-cycle pop frees a slot, so a full FIFO still streams 1/cycle.
  assign push_s    = (state_q == S_FETCH) & ~redirect_valid & (~full_s | pop_s);
  assign id_instr  = empty_s ? NOP_INSTR : instr_mem[rd_ptr_q];
  assign id_pc     = empty_s ? 32'h0000_0000 : pc_mem[rd_ptr_q];
  assign fetch_err = fetch_err_q;

  // Control FSM, fetch PC, FIFO pointers/count and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      count_q     <= {CW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      fetch_err_q <= 1'b0;
    end else begin
      fetch_err_q <= fetch_err_q | misalign_s;

      if (misalign_s) begin
        state_q <= S_HALT;
      end else begin
        case (state_q)
          S_BOOT:  state_q <= S_FETCH;
          S_FETCH: state_q <= S_FETCH;
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_BOOT;
        endcase
      end

      if (redirect_valid) begin
        count_q    <= {CW{1'b0}};
        rd_ptr_q   <= {PW{1'b0}};
        wr_ptr_q   <= {PW{1'b0}};
        fetch_pc_q <= redirect_tgt_s;
      end else begin
        if (push_s) begin
          wr_ptr_q   <= wr_ptr_q + PW'(1'b1);
          fetch_pc_q <= fetch_pc_q + 32'd4;
        end
        if (pop_s) begin
          rd_ptr_q <= rd_ptr_q + PW'(1'b1);
        end
        case ({push_s, pop_s})
          2'b10:   count_q <= count_q + CW'(1'b1);
          2'b01:   count_q <= count_q - CW'(1'b1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem[wr_ptr_q]    <= fetch_pc_q;
      instr_mem[wr_ptr_q] <= imem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int n_checks;
  int n_errors;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a scrambled function of the word index.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return ({2'b00, a[31:2]} * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_data = rom(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic        emp;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic ready, input logic redir,
                              input logic [31:0] rpc, input logic ev, input logic emp,
                              input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.emp = emp; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  vec_t tv[$];

  // Reference model state
  ent_t        mq[$];
  logic [31:0] mpc;
  int          mphase;   // 0 boot, 1 fetch, 2 halt
  logic        merr;

  initial begin
    logic [31:0] e_instr;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // Streaming from reset
    tv.push_back(mk(1'b1,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h4));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4,32'h8));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h8,32'hC));
    // Stall for 10 cycles then release
    tv.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h4));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h8));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'hC));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h10));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h10));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4,32'h14));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h8,32'h18));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'hC,32'h1C));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h10,32'h20));
    // Redirect while full
    tv.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h0));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h4));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h8));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'hC));
    tv.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h10));
    tv.push_back(mk(1'b0,1'b0,1'b1,32'h40, 1'b0,1'b0,32'h0,32'h10));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h40));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h40,32'h44));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h44,32'h48));
    // Back-to-back redirects
    tv.push_back(mk(1'b0,1'b1,1'b1,32'h80, 1'b0,1'b0,32'h48,32'h4C));
    tv.push_back(mk(1'b0,1'b1,1'b1,32'h100, 1'b0,1'b1,32'h0,32'h80));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'h100));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h100,32'h104));
    // Wrap at the top of the address space
    tv.push_back(mk(1'b0,1'b1,1'b1,32'hFFFF_FFF8, 1'b0,1'b0,32'h104,32'h108));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b0,1'b1,32'h0,32'hFFFF_FFF8));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'hFFFF_FFF8,32'hFFFF_FFFC));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'hFFFF_FFFC,32'h0));
    tv.push_back(mk(1'b0,1'b1,1'b0,32'h0, 1'b1,1'b0,32'h0,32'h4));

    foreach (tv[i]) begin
      @(negedge clk);
      reset          = tv[i].rst;
      id_ready       = tv[i].ready;
      redirect_valid = tv[i].redir;
      redirect_pc    = tv[i].rpc;
      #1;
      e_instr = tv[i].emp ? NOP_INSTR : rom(tv[i].epc);
      chk($sformatf("vec%0d.id_valid", i), {31'd0, id_valid}, {31'd0, tv[i].ev});
      chk($sformatf("vec%0d.id_pc", i), id_pc, tv[i].epc);
      chk($sformatf("vec%0d.id_instr", i), id_instr, e_instr);
      chk($sformatf("vec%0d.imem_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("vec%0d.fetch_err", i), {31'd0, fetch_err}, 32'd0);
    end

    // Misaligned redirect, then reset mid-stream
    @(negedge clk);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int k = 0; k < 8; k++) begin
      chk("halt.fetch_err", {31'd0, fetch_err}, 32'd1);
      chk("halt.id_valid", {31'd0, id_valid}, 32'd0);
      @(negedge clk);
      #1;
    end
`else
    chk("mis.imem_addr", imem_addr, 32'h40);
    chk("mis.fetch_err", {31'd0, fetch_err}, 32'd0);
    @(negedge clk);
    #1;
    chk("mis.id_valid", {31'd0, id_valid}, 32'd1);
    chk("mis.id_pc", id_pc, 32'h40);
    @(negedge clk);
    #1;
    chk("mis.id_pc2", id_pc, 32'h44);
`endif
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst.id_valid", {31'd0, id_valid}, 32'd0);
    chk("arst.id_pc", id_pc, 32'h0);
    chk("arst.id_instr", id_instr, NOP_INSTR);
    chk("arst.imem_addr", imem_addr, RESET_PC);
    chk("arst.fetch_err", {31'd0, fetch_err}, 32'd0);

    // Randomized run against the queue model
    mq.delete();
    mpc = RESET_PC;
    mphase = 0;
    merr = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        e_valid;
      logic [31:0] e_pc;
      logic        do_pop;
      logic        do_push;
      @(negedge clk);
      reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
      if ($urandom_range(0, 9) != 0) redirect_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      #1;
      if (reset) begin
        mq.delete();
        mpc = RESET_PC;
        mphase = 0;
        merr = 1'b0;
      end
      e_valid = (mq.size() != 0) && !redirect_valid;
      e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
      e_instr = (mq.size() != 0) ? mq[0].instr : NOP_INSTR;
      chk("rnd.id_valid", {31'd0, id_valid}, {31'd0, e_valid});
      chk("rnd.id_pc", id_pc, e_pc);
      chk("rnd.id_instr", id_instr, e_instr);
      chk("rnd.imem_addr", imem_addr, mpc);
      chk("rnd.fetch_err", {31'd0, fetch_err}, {31'd0, merr});
      if (!reset) begin
        if (redirect_valid) begin
          mq.delete();
`ifdef FETCH_MISALIGN_CHK_EN
          mpc = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            merr = 1'b1;
            mphase = 2;
          end else if (mphase == 0) begin
            mphase = 1;
          end
`else
          mpc = {redirect_pc[31:2], 2'b00};
          if (mphase == 0) mphase = 1;
`endif
        end else begin
          do_pop  = e_valid && id_ready;
          do_push = (mphase == 1) && ((mq.size() < DEPTH) || do_pop);
          if (do_pop) void'(mq.pop_front());
          if (do_push) begin
            mq.push_back('{pc: mpc, instr: rom(mpc)});
            mpc = mpc + 32'd4;
          end
          if (mphase == 0) mphase = 1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
